lsu_request_ctrl: RTL and testbench
===================================

Name: lsu_request_ctrl

Overview:
- Initiator-side load/store unit between the execute stage and the byte-addressed data RAM.
- Accepts one load or store per handshake from the pipeline and issues word-aligned memory requests with byte enables.
- Splits misaligned accesses into two word transactions and merges, sign- or zero-extends load data.
- Returns one response to writeback, with a watchdog on memory response latency.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles waiting for mem_rvalid before an error response.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept request
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  ir[14:12] access size/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- req_rd  in  5  load destination register
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_rvalid  in  1  read/write completion
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  extended load data, 0 for stores
- rsp_rd  out  5  echoed rd, 0 for stores
- rsp_err  out  1  illegal funct3 or timeout

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE.
  - Outputs req_ready=1; mem_valid, mem_we, mem_be, mem_addr, mem_wdata = 0; rsp_* = 0.
  - Watchdog counter cleared.
  - Reset mid-transaction abandons it; no response is emitted.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch all req_* fields.
  - Legal funct3:
    - loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
    - stores: 0 SB, 1 SH, 2 SW.
  - Illegal funct3: go to RESP with rsp_err=1; no memory access.
  - Otherwise go to ISSUE0.
- Split rule: with off=addr[1:0] and size 1/2/4 bytes, the access needs two words when off+size>4.
  - Word0 = addr & ~3, be0 = lanes off..min(3, off+size-1).
  - Word1 = word0+4, be1 = remaining low lanes.
- Store data is shifted left by 8*off bits. Word1 carries the high bytes in its low lanes.
- ISSUE0/ISSUE1:
  - mem_valid=1 with stable addr/be/we/wdata until the cycle mem_ready=1.
  - Then go to WAIT0/WAIT1. mem_valid drops the following cycle.
- WAIT0/WAIT1:
  - Watchdog increments each cycle.
  - On mem_rvalid:
    - loads capture the enabled lanes of mem_rdata into a 64-bit assembly buffer, word0 into [31:0] and word1 into [63:32];
    - next state is ISSUE1 if split, else RESP;
    - watchdog clears.
  - On watchdog reaching TIMEOUT: go to RESP with rsp_err=1.
- mem_rvalid while in ISSUE or IDLE is ignored.
- RESP (one cycle):
  - rsp_valid=1. Load data = buffer >> 8*off, truncated to size.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU/LW.
  - Next state IDLE; req_ready returns the following cycle.
- Latency (aligned access, mem_ready and mem_rvalid each answered in one cycle):
  - request accepted cycle 0, mem_valid cycle 1, rvalid cycle 2, rsp_valid cycle 3.
  - Split access adds 2 cycles.
- Address wrap: word1 of 0xFFFFFFFC+4 wraps to 0 (modulo 2^ADDR_W).
- One outstanding transaction; req_ready=0 outside IDLE.

Decomposition:
- The funct3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW) and LTYPE/STYPE go in the shared itype include, next to the existing load op codes.
- One sub-module: lsu_lane_align.
  - Combinational.
  - Computes be0/be1 and shifted wdata from off/size, and extracts/extends load data from the 64-bit buffer.
- FSM and watchdog stay in the top module.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF → one mem access, be=1111, rsp_data=0xDEADBEEF, rsp_rd echoed, latency 3.
- LB addr 0x103, word 0x80112233 → be=1000, rsp_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- SW 0xAABBCCDD to 0x102 → two writes:
  - 0x100 be=1100 wdata=0xCCDD0000;
  - 0x104 be=0011 wdata=0x0000AABB.
  - Then rsp_valid, rsp_err=0.
- LH addr 0x107 with words 0x11xxxxxx at 0x104 and 0xxxxxxx80 at 0x108 → be0=1000, be1=0001, rsp_data=0xFFFF8011.
- funct3=3 load → no mem_valid, rsp_err=1 one cycle after acceptance. mem_rvalid withheld for 255 cycles → rsp_err=1.
- Assert reset during WAIT1 → all outputs 0 immediately, req_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/lsu_request_ctrl_pkg.sv
// Shared load/store encodings, FSM state type and small helpers for the LSU request path.
package lsu_request_ctrl_pkg;

    localparam logic [6:0] LTYPE  = 7'b0000011;
    localparam logic [6:0] STYPE  = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } lsu_state_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
        end
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and shifted store data per word, and
// extraction plus sign/zero extension of load data from the two-word buffer.
module lsu_lane_align
    import lsu_request_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rbuf,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);
    logic [7:0]  size_mask_s;
    logic [7:0]  lanes_s;
    logic [63:0] wshift_s;
    logic [63:0] rshift_s;

    // Lanes covered by the access size before applying the byte offset.
    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask_s = 8'h01;
            2'b01:   size_mask_s = 8'h03;
            default: size_mask_s = 8'h0F;
        endcase
    end

    // Lanes beyond bit 3 spill into the next word.
    assign lanes_s  = size_mask_s << off;
    assign be0      = lanes_s[3:0];
    assign be1      = lanes_s[7:4];
    assign split    = |lanes_s[7:4];
    assign wshift_s = {32'h0000_0000, wdata} << {off, 3'b000};
    assign wdata0   = wshift_s[31:0];
    assign wdata1   = wshift_s[63:32];
    assign rshift_s = rbuf >> {off, 3'b000};

    // Truncate to the access size and extend.
    always_comb begin
        case (funct3)
            F3_LB:   rdata = {{24{rshift_s[7]}}, rshift_s[7:0]};
            F3_LH:   rdata = {{16{rshift_s[15]}}, rshift_s[15:0]};
            F3_LW:   rdata = rshift_s[31:0];
            F3_LBU:  rdata = {24'h00_0000, rshift_s[7:0]};
            F3_LHU:  rdata = {16'h0000, rshift_s[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_request_ctrl.sv
// LSU request controller: accepts one load/store, issues one or two word-aligned
// memory transactions and returns a single writeback response.
module lsu_request_ctrl
    import lsu_request_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_r;
    logic              store_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [4:0]        rd_r;
    logic [WD_W-1:0]   wdog_r;
    logic [63:0]       rbuf_r;

    logic              idle_s;
    logic [2:0]        sel_funct3_s;
    logic [1:0]        sel_off_s;
    logic [31:0]       sel_wdata_s;
    logic [ADDR_W-1:0] word0_s;
    logic [63:0]       rbuf_merge_s;
    logic [3:0]        be0_s;
    logic [3:0]        be1_s;
    logic              split_s;
    logic [31:0]       wdata0_s;
    logic [31:0]       wdata1_s;
    logic [31:0]       rdata_s;

    // In IDLE the first word is launched from the live request, before the latches update.
    assign idle_s       = (state_r == S_IDLE);
    assign sel_funct3_s = idle_s ? req_funct3 : funct3_r;
    assign sel_off_s    = idle_s ? req_addr[1:0] : addr_r[1:0];
    assign sel_wdata_s  = idle_s ? req_wdata : wdata_r;
    assign word0_s      = idle_s ? {req_addr[ADDR_W-1:2], 2'b00} : {addr_r[ADDR_W-1:2], 2'b00};

    lsu_lane_align u_align (
        .funct3 (sel_funct3_s),
        .off    (sel_off_s),
        .wdata  (sel_wdata_s),
        .rbuf   (rbuf_merge_s),
        .be0    (be0_s),
        .be1    (be1_s),
        .split  (split_s),
        .wdata0 (wdata0_s),
        .wdata1 (wdata1_s),
        .rdata  (rdata_s)
    );

    // Assembly buffer including the word returning this cycle, so RESP sees complete data.
    always_comb begin
        rbuf_merge_s = rbuf_r;
        if (mem_rvalid && !store_r && (state_r == S_WAIT0)) begin
            rbuf_merge_s[31:0]  = (rbuf_r[31:0] & ~lane_mask(be0_s)) | (mem_rdata & lane_mask(be0_s));
        end else if (mem_rvalid && !store_r && (state_r == S_WAIT1)) begin
            rbuf_merge_s[63:32] = (rbuf_r[63:32] & ~lane_mask(be1_s)) | (mem_rdata & lane_mask(be1_s));
        end else begin
            rbuf_merge_s = rbuf_r;
        end
    end

    // Request FSM, watchdog and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            store_r   <= 1'b0;
            funct3_r  <= 3'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'h0000_0000;
            rd_r      <= 5'd0;
            wdog_r    <= {WD_W{1'b0}};
            rbuf_r    <= 64'h0;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
            rbuf_r    <= rbuf_merge_s;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        store_r   <= req_store;
                        funct3_r  <= req_funct3;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        rd_r      <= req_rd;
                        rbuf_r    <= 64'h0;
                        wdog_r    <= {WD_W{1'b0}};
                        req_ready <= 1'b0;
                        if (f3_legal(req_store, req_funct3)) begin
                            state_r   <= S_ISSUE0;
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= word0_s;
                            mem_be    <= be0_s;
                            mem_wdata <= req_store ? wdata0_s : 32'h0000_0000;
                        end else begin
                            state_r   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rd    <= req_store ? 5'd0 : req_rd;
                        end
                    end
                end
                S_ISSUE0, S_ISSUE1: begin
                    if (mem_ready) begin
                        state_r   <= (state_r == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= {ADDR_W{1'b0}};
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0000_0000;
                        wdog_r    <= {WD_W{1'b0}};
                    end
                end
                S_WAIT0, S_WAIT1: begin
                    if (mem_rvalid) begin
                        wdog_r <= {WD_W{1'b0}};
                        if ((state_r == S_WAIT0) && split_s) begin
                            state_r   <= S_ISSUE1;
                            mem_valid <= 1'b1;
                            mem_we    <= store_r;
                            mem_addr  <= word0_s + ADDR_W'(4);
                            mem_be    <= be1_s;
                            mem_wdata <= store_r ? wdata1_s : 32'h0000_0000;
                        end else begin
                            state_r   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= store_r ? 32'h0000_0000 : rdata_s;
                            rsp_rd    <= store_r ? 5'd0 : rd_r;
                        end
                    end else if (wdog_r == WD_W'(TIMEOUT - 1)) begin
                        state_r   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rd    <= store_r ? 5'd0 : rd_r;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                S_RESP: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_request_ctrl.sv
// Directed bench for lsu_request_ctrl: byte-level memory model, per-request expectations
// derived from byte addresses, and literal checks for the documented scenarios.
module tb_lsu_request_ctrl;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    always #5 clk = ~clk;

    lsu_request_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } mtx_t;
    typedef struct { logic [31:0] data; logic [4:0] rd; logic err; int lat; int acc; } rsp_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] mem_b [logic [31:0]];
    mtx_t exp_mem[$];
    rsp_t exp_rsp[$];
    logic [31:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wd[$];

    int rdy_delay = 0, rv_delay0 = 0, rv_delay1 = 0;
    int rdy_wait = 0, pend_wait = 0, hs_idx = 0, rsp_seen = 0, last_lat = 0;
    bit hs = 1'b0, pend = 1'b0, hs_we = 1'b0;
    logic [31:0] hs_addr = 32'h0, hs_wd = 32'h0, pend_data = 32'h0;
    logic [3:0]  hs_be = 4'h0;
    logic [31:0] last_data = 32'h0;
    logic [4:0]  last_rd = 5'd0;
    logic        last_err = 1'b0;
    mtx_t mem_e;
    rsp_t rsp_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : 8'h00;
    endfunction

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) mem_b[a + 32'(k)] = d[8*k +: 8];
    endtask

    // Expected memory traffic and response, derived byte by byte from the request.
    task automatic model_push(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] rd, input bit skip_lat, input bit tmo);
        int size;
        bit legal, split;
        logic [31:0] w0, ba, wd0, wd1, v;
        logic [3:0] be0, be1;
        mtx_t m;
        rsp_t r;
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        w0 = a & ~32'h3; be0 = 4'h0; be1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0; v = 32'h0; split = 1'b0;
        for (int k = 0; k < size; k++) begin
            ba = a + 32'(k);
            if ((ba & ~32'h3) == w0) begin
                be0[ba[1:0]] = 1'b1;
                wd0[8*ba[1:0] +: 8] = wd[8*k +: 8];
            end else begin
                split = 1'b1;
                be1[ba[1:0]] = 1'b1;
                wd1[8*ba[1:0] +: 8] = wd[8*k +: 8];
            end
            v[8*k +: 8] = rd_byte(ba);
        end
        if (f3 == 3'd0 && v[7])  v[31:8]  = 24'hFF_FFFF;
        if (f3 == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (legal) begin
            m.addr = w0; m.be = be0; m.we = st; m.wdata = wd0;
            exp_mem.push_back(m);
            if (split) begin
                m.addr = w0 + 32'd4; m.be = be1; m.wdata = wd1;
                exp_mem.push_back(m);
            end
        end
        r.err  = !legal || tmo;
        r.data = (r.err || st) ? 32'h0 : v;
        r.rd   = st ? 5'd0 : rd;
        r.lat  = skip_lat ? -1 : (!legal ? 1 : (tmo ? 2 + TIMEOUT : (split ? 5 : 3)));
        r.acc  = cyc;
        exp_rsp.push_back(r);
    endtask

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input bit skip_lat, input bit tmo);
        int n;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready_idle", req_ready, 1'b1);
        log_addr.delete(); log_be.delete(); log_wd.delete();
        hs_idx = 0;
        model_push(st, f3, a, wd, rd, skip_lat, tmo);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input bit skip_lat, input bit tmo);
        int n;
        send(st, f3, a, wd, rd, skip_lat, tmo);
        n = 0;
        while (exp_rsp.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check("rsp_within_budget", 64'(exp_rsp.size()), 64'd0);
        @(negedge clk);
    endtask

    // Memory responder and the single output compare process.
    always @(negedge clk) begin
        if (!reset) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            hs = 1'b0; pend = 1'b0; rdy_wait = 0;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
            if (hs) begin
                hs = 1'b0; mem_ready = 1'b0;
                if (hs_we) begin
                    for (int k = 0; k < 4; k++) if (hs_be[k]) mem_b[hs_addr + 32'(k)] = hs_wd[8*k +: 8];
                end
                pend_data = {rd_byte(hs_addr + 32'd3), rd_byte(hs_addr + 32'd2),
                             rd_byte(hs_addr + 32'd1), rd_byte(hs_addr)};
                pend = 1'b1;
                pend_wait = (hs_idx == 0) ? rv_delay0 : rv_delay1;
                hs_idx++;
            end
            if (pend) begin
                if (pend_wait == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = pend_data; pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            if (mem_valid) begin
                check("mem_req_expected", 64'(exp_mem.size() != 0), 64'd1);
                if (exp_mem.size() != 0) begin
                    mem_e = exp_mem[0];
                    check("mem_addr", mem_addr, mem_e.addr);
                    check("mem_be", mem_be, mem_e.be);
                    check("mem_we", mem_we, mem_e.we);
                    if (mem_e.we) check("mem_wdata", mem_wdata, mem_e.wdata);
                    if (rdy_wait >= rdy_delay) begin
                        mem_ready = 1'b1; hs = 1'b1; rdy_wait = 0;
                        hs_addr = mem_addr; hs_be = mem_be; hs_we = mem_we; hs_wd = mem_wdata;
                        log_addr.push_back(mem_addr); log_be.push_back(mem_be); log_wd.push_back(mem_wdata);
                        void'(exp_mem.pop_front());
                    end else begin
                        rdy_wait++;
                    end
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                pend = 1'b0;
                last_data = rsp_data; last_rd = rsp_rd; last_err = rsp_err;
                check("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
                if (exp_rsp.size() != 0) begin
                    rsp_e = exp_rsp.pop_front();
                    last_lat = cyc - rsp_e.acc;
                    check("rsp_data", rsp_data, rsp_e.data);
                    check("rsp_rd", rsp_rd, rsp_e.rd);
                    check("rsp_err", rsp_err, rsp_e.err);
                    check("req_ready_busy", req_ready, 1'b0);
                    if (rsp_e.lat >= 0) check("rsp_latency", 64'(last_lat), 64'(rsp_e.lat));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_outputs", {mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_rd, rsp_err}, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        wr_word(32'h100, 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd7, 1'b0, 1'b0);
        check("lw_data", last_data, 32'hDEADBEEF);
        check("lw_be", log_be[0], 4'b1111);
        check("lw_nmem", 64'(log_addr.size()), 64'd1);
        check("lw_rd", last_rd, 5'd7);
        check("lw_latency", 64'(last_lat), 64'd3);

        wr_word(32'h100, 32'h80112233);
        do_req(1'b0, 3'd0, 32'h103, 32'h0, 5'd3, 1'b0, 1'b0);
        check("lb_data", last_data, 32'hFFFFFF80);
        check("lb_be", log_be[0], 4'b1000);
        do_req(1'b0, 3'd4, 32'h103, 32'h0, 5'd3, 1'b0, 1'b0);
        check("lbu_data", last_data, 32'h00000080);

        do_req(1'b1, 3'd2, 32'h102, 32'hAABBCCDD, 5'd9, 1'b0, 1'b0);
        check("sw_nmem", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("sw_addr0", log_addr[0], 32'h100);
            check("sw_be0", log_be[0], 4'b1100);
            check("sw_wd0", log_wd[0], 32'hCCDD0000);
            check("sw_addr1", log_addr[1], 32'h104);
            check("sw_be1", log_be[1], 4'b0011);
            check("sw_wd1", log_wd[1], 32'h0000AABB);
        end
        check("sw_err", last_err, 1'b0);

        wr_word(32'h104, 32'h11223344);
        wr_word(32'h108, 32'h55667780);
        do_req(1'b0, 3'd1, 32'h107, 32'h0, 5'd12, 1'b0, 1'b0);
        check("lh_split_data", last_data, 32'hFFFF8011);
        check("lh_split_nmem", 64'(log_addr.size()), 64'd2);
        if (log_be.size() == 2) begin
            check("lh_be0", log_be[0], 4'b1000);
            check("lh_be1", log_be[1], 4'b0001);
        end

        do_req(1'b0, 3'd3, 32'h100, 32'h0, 5'd4, 1'b0, 1'b0);
        check("illegal_err", last_err, 1'b1);
        check("illegal_nmem", 64'(log_addr.size()), 64'd0);
        check("illegal_latency", 64'(last_lat), 64'd1);
        do_req(1'b1, 3'd4, 32'h100, 32'h1234, 5'd4, 1'b0, 1'b0);

        // Model-only vectors: other sizes and offsets, address wrap, slow memory.
        do_req(1'b1, 3'd0, 32'h105, 32'h0000005A, 5'd1, 1'b0, 1'b0);
        do_req(1'b1, 3'd1, 32'h10E, 32'h0000BEEF, 5'd1, 1'b0, 1'b0);
        do_req(1'b1, 3'd1, 32'h10F, 32'h0000C3A5, 5'd1, 1'b0, 1'b0);
        do_req(1'b0, 3'd5, 32'h10F, 32'h0, 5'd21, 1'b0, 1'b0);
        do_req(1'b0, 3'd1, 32'h10E, 32'h0, 5'd22, 1'b0, 1'b0);
        do_req(1'b0, 3'd2, 32'h105, 32'h0, 5'd23, 1'b0, 1'b0);
        wr_word(32'hFFFFFFFC, 32'h12345678);
        wr_word(32'h00000000, 32'h9ABCDEF0);
        do_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 5'd30, 1'b0, 1'b0);
        check("wrap_data", last_data, 32'hDEF01234);
        if (log_addr.size() == 2) check("wrap_addr1", log_addr[1], 32'h0);
        rdy_delay = 2; rv_delay0 = 3; rv_delay1 = 1;
        do_req(1'b0, 3'd0, 32'h10D, 32'h0, 5'd5, 1'b1, 1'b0);
        do_req(1'b1, 3'd2, 32'h10B, 32'h01020304, 5'd5, 1'b1, 1'b0);
        do_req(1'b0, 3'd2, 32'h10B, 32'h0, 5'd6, 1'b1, 1'b0);
        rdy_delay = 0; rv_delay0 = 0; rv_delay1 = 0;

        rv_delay0 = 1000;
        do_req(1'b0, 3'd2, 32'h200, 32'h0, 5'd15, 1'b0, 1'b1);
        check("timeout_err", last_err, 1'b1);
        check("timeout_latency", 64'(last_lat), 64'(2 + TIMEOUT));
        rv_delay0 = 0;

        // Reset while waiting for the second word of a split load.
        rv_delay1 = 100;
        send(1'b0, 3'd2, 32'h301, 32'h0, 5'd8, 1'b0, 1'b0);
        n = 0;
        while (exp_mem.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("pre_reset_both_issued", 64'(log_addr.size()), 64'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_outputs", {mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_data, rsp_rd, rsp_err}, 64'h0);
        exp_rsp.delete(); exp_mem.delete();
        rv_delay1 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", req_ready, 1'b1);
        n = rsp_seen;
        repeat (10) @(negedge clk);
        check("post_reset_no_rsp", 64'(rsp_seen - n), 64'd0);

        do_req(1'b0, 3'd2, 32'h100, 32'h0, 5'd2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
